// File: rtl/pcr_access_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle for pcr_access_arbiter: core and host request/response channels
// plus the live STATUS tap. "master" is the requester side, "slave" the arbiter.
interface pcr_access_arbiter_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 8;

    logic              core_req_valid;
    logic              core_req_ready;
    logic              core_req_rw;
    logic [ADDR_W-1:0] core_req_addr;
    logic [DATA_W-1:0] core_req_data;
    logic              core_resp_valid;
    logic [DATA_W-1:0] core_resp_data;

    logic              host_req_valid;
    logic              host_req_ready;
    logic              host_req_rw;
    logic [ADDR_W-1:0] host_req_addr;
    logic [DATA_W-1:0] host_req_data;
    logic              host_resp_valid;
    logic              host_resp_ready;
    logic [DATA_W-1:0] host_resp_data;

    logic [STAT_W-1:0] status_im;

    modport master (
        output core_req_valid, core_req_rw, core_req_addr, core_req_data,
        input  core_req_ready, core_resp_valid, core_resp_data,
        output host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
        input  host_req_ready, host_resp_valid, host_resp_data,
        input  status_im
    );

    modport slave (
        input  core_req_valid, core_req_rw, core_req_addr, core_req_data,
        output core_req_ready, core_resp_valid, core_resp_data,
        input  host_req_valid, host_req_rw, host_req_addr, host_req_data, host_resp_ready,
        output host_req_ready, host_resp_valid, host_resp_data,
        output status_im
    );
endinterface

// File: rtl/pcr_access_arbiter.sv
`timescale 1ns/1ps
// Two-requester (core/host) arbiter for a small 64-bit register file: STATUS, SCRATCH, COUNT.
// Define PCR_ARB_ROUND_ROBIN_EN for round-robin grant; default build gives the core fixed priority.
module pcr_access_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    pcr_access_arbiter_if.slave  bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_COUNT   = ADDR_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_CRESP  = 2'd2,
        ST_HRESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              req_host_q;
    logic              req_rw_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_data_q;

    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] scratch_q;
    logic [DATA_W-1:0] count_q;

    logic              core_resp_valid_q;
    logic [DATA_W-1:0] core_resp_data_q;
    logic              host_resp_valid_q;
    logic [DATA_W-1:0] host_resp_data_q;

    logic              grant_core_c;
    logic              grant_host_c;
    logic              accept_core_c;
    logic              accept_host_c;
    logic              in_access_c;
    logic              wr_status_c;
    logic              wr_scratch_c;
    logic              wr_count_c;
    logic [DATA_W-1:0] rdata_c;

`ifdef PCR_ARB_ROUND_ROBIN_EN
    logic              last_host_q;
`endif

    // Grant selection; only matters when both requesters are valid.
    always_comb begin
        grant_core_c = 1'b0;
        grant_host_c = 1'b0;
        if (bus.core_req_valid && bus.host_req_valid) begin
`ifdef PCR_ARB_ROUND_ROBIN_EN
            grant_core_c = last_host_q;
            grant_host_c = !last_host_q;
`else
            grant_core_c = 1'b1;
`endif
        end else begin
            grant_core_c = bus.core_req_valid;
            grant_host_c = bus.host_req_valid;
        end
    end

    assign accept_core_c = (state_q == ST_IDLE) && !reset && grant_core_c;
    assign accept_host_c = (state_q == ST_IDLE) && !reset && grant_host_c;

    assign bus.core_req_ready = accept_core_c;
    assign bus.host_req_ready = accept_host_c;

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_core_c || accept_host_c) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = req_host_q ? ST_HRESP : ST_CRESP;
            end
            ST_CRESP: begin
                state_d = ST_IDLE;
            end
            ST_HRESP: begin
                if (bus.host_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access decode: reads always return the current (pre-write) register value.
    always_comb begin : access_decode
        in_access_c  = (state_q == ST_ACCESS);
        wr_status_c  = 1'b0;
        wr_scratch_c = 1'b0;
        wr_count_c   = 1'b0;
        rdata_c      = '0;
        case (req_addr_q)
            ADDR_STATUS:  rdata_c = status_q;
            ADDR_SCRATCH: rdata_c = scratch_q;
            ADDR_COUNT:   rdata_c = count_q;
            default:      rdata_c = '0;
        endcase
        if (in_access_c && req_rw_q) begin
            wr_status_c  = (req_addr_q == ADDR_STATUS);
            wr_scratch_c = (req_addr_q == ADDR_SCRATCH);
            wr_count_c   = (req_addr_q == ADDR_COUNT);
        end
    end

    always_ff @(posedge clk) begin : req_latch
        if (reset) begin
            req_host_q <= 1'b0;
            req_rw_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else if (accept_core_c) begin
            req_host_q <= 1'b0;
            req_rw_q   <= bus.core_req_rw;
            req_addr_q <= bus.core_req_addr;
            req_data_q <= bus.core_req_data;
        end else if (accept_host_c) begin
            req_host_q <= 1'b1;
            req_rw_q   <= bus.host_req_rw;
            req_addr_q <= bus.host_req_addr;
            req_data_q <= bus.host_req_data;
        end
    end

`ifdef PCR_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin : last_grant_reg
        if (reset) begin
            last_host_q <= 1'b1;
        end else if (accept_core_c || accept_host_c) begin
            last_host_q <= accept_host_c;
        end
    end
`endif

    always_ff @(posedge clk) begin : reg_file
        if (reset) begin
            status_q  <= '0;
            scratch_q <= '0;
        end else begin
            if (wr_status_c) begin
                status_q <= req_data_q;
            end
            if (wr_scratch_c) begin
                scratch_q <= req_data_q;
            end
        end
    end

    // Free-running counter; a write in the same cycle wins over the increment.
    always_ff @(posedge clk) begin : count_reg
        if (reset) begin
            count_q <= '0;
        end else if (wr_count_c) begin
            count_q <= req_data_q;
        end else begin
            count_q <= count_q + DATA_W'(1);
        end
    end

    // Response registers; data is forced to zero whenever valid is low.
    always_ff @(posedge clk) begin : resp_regs
        if (reset) begin
            core_resp_valid_q <= 1'b0;
            core_resp_data_q  <= '0;
            host_resp_valid_q <= 1'b0;
            host_resp_data_q  <= '0;
        end else begin
            core_resp_valid_q <= in_access_c && !req_host_q;
            core_resp_data_q  <= (in_access_c && !req_host_q) ? rdata_c : '0;
            if (in_access_c && req_host_q) begin
                host_resp_valid_q <= 1'b1;
                host_resp_data_q  <= rdata_c;
            end else if ((state_q == ST_HRESP) && bus.host_resp_ready) begin
                host_resp_valid_q <= 1'b0;
                host_resp_data_q  <= '0;
            end
        end
    end

    assign bus.core_resp_valid = core_resp_valid_q;
    assign bus.core_resp_data  = core_resp_data_q;
    assign bus.host_resp_valid = host_resp_valid_q;
    assign bus.host_resp_data  = host_resp_data_q;
    assign bus.status_im       = status_q[STAT_W-1:0];

    // Protocol invariants.
    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        !(bus.core_req_ready && bus.host_req_ready));
    a_core_pulse: assert property (@(posedge clk) disable iff (reset)
        bus.core_resp_valid |=> !bus.core_resp_valid);
    a_core_data_zero: assert property (@(posedge clk) disable iff (reset)
        !bus.core_resp_valid |-> (bus.core_resp_data == '0));
    a_host_data_zero: assert property (@(posedge clk) disable iff (reset)
        !bus.host_resp_valid |-> (bus.host_resp_data == '0));
    a_host_hold: assert property (@(posedge clk) disable iff (reset)
        (bus.host_resp_valid && !bus.host_resp_ready) |=>
            (bus.host_resp_valid && $stable(bus.host_resp_data)));
endmodule

// File: doc/pcr_access_arbiter.md
PCR_ACCESS_ARBITER -- requirements
Module: pcr_access_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: core_req_valid input 1; core_req_ready output 1; core_req_rw input 1 (1=write); core_req_addr input 5; core_req_data input 64.
REQ-004 SHALL have ports: core_resp_valid output 1 (one-cycle pulse, no backpressure); core_resp_data output 64.
REQ-005 SHALL have ports: host_req_valid input 1; host_req_ready output 1; host_req_rw input 1; host_req_addr input 5; host_req_data input 64.
REQ-006 SHALL have ports: host_resp_valid output 1; host_resp_ready input 1; host_resp_data output 64.
REQ-007 SHALL have port: status_im  output  8  live copy of STATUS[7:0].

Function
REQ-008 SHALL own three 64-bit registers: addr 0 STATUS, addr 1 SCRATCH, addr 2 COUNT; other addresses read 0, writes ignored.
REQ-009 SHALL run an FSM with states IDLE, ACCESS, CRESP, HRESP.
REQ-010 SHALL assert req_ready only in IDLE, only to the granted requester, combinationally from the valids.
REQ-011 SHALL, on a valid&ready handshake in IDLE, latch rw/addr/data and requester id and go to ACCESS.
REQ-012 SHALL, in ACCESS, perform the write (committed at end of that cycle) or capture read data, then go to CRESP (core) or HRESP (host).
REQ-013 SHALL return on a write the register's pre-write value (read-modify-write semantics).
REQ-014 SHALL in CRESP drive core_resp_valid=1 for exactly one cycle, then go to IDLE; total latency handshake edge N -> core_resp_valid in cycle N+2.
REQ-015 SHALL in HRESP hold host_resp_valid=1 and host_resp_data stable until host_resp_ready=1, then go to IDLE in the next cycle.
REQ-016 SHALL increment COUNT by 1 every cycle modulo 2^64 (wraps 0xFFFF_FFFF_FFFF_FFFF -> 0).
REQ-017 SHALL give a COUNT write priority over the increment in the same cycle; the next cycle holds the written value, incrementing thereafter.
REQ-018 SHALL capture COUNT read data as the register value in the ACCESS cycle (pre-increment).
REQ-019 SHALL drive status_im from STATUS[7:0], updating the cycle after a STATUS write commits.
REQ-020 SHALL keep resp_data outputs at 0 whenever the corresponding resp_valid is 0.
REQ-021 SHALL not accept any new request outside IDLE; requesters hold valid until ready.

Reset
REQ-022 SHALL on reset set state IDLE, STATUS/SCRATCH/COUNT to 0, all valid/ready outputs to 0, status_im to 0, last-grant to host.
REQ-023 SHALL on reset mid-transaction abandon the pending access and response; no write commits in the reset cycle.

Configuration
REQ-024 SHALL, with PCR_ARB_ROUND_ROBIN_EN defined, on simultaneous valids grant the requester not granted last; a single valid is always granted.
REQ-025 SHALL, without PCR_ARB_ROUND_ROBIN_EN, always grant core over host on simultaneous valids; last-grant register absent.

Verification
REQ-026 Core write SCRATCH=0x1234 at edge N -> core_resp_valid at N+2 with data 0; later core read addr 1 -> 0x1234.
REQ-027 Host write STATUS=0xA5, host_resp_ready held 0 for 3 cycles -> host_resp_valid held 4 cycles total, data stable at 0; status_im=0xA5; core_req_ready=0 throughout.
REQ-028 Both valids asserted continuously, 4 transactions -> with macro grants core,host,core,host; without macro core,core,core,core.
REQ-029 Host write COUNT=0xFFFF_FFFF_FFFF_FFFE -> next cycles read 0xFFFF_FFFF_FFFF_FFFE, 0xFFFF_FFFF_FFFF_FFFF, then wrap to 0.
REQ-030 Reset asserted in ACCESS of a SCRATCH write of 0x55 -> no resp_valid, SCRATCH reads 0, FSM IDLE next cycle.
REQ-031 Core read addr 7 and write addr 9 -> read returns 0, write has no effect on any register.
